clock_phase_sequencer: RTL

Single-clock phase sequencer that consumes the board clock and produces the per-stage strobes and the stretched processor reset that drive the processor pipeline and the clock-extension stage. It replaces ad-hoc divided clocks with clock enables: one processor cycle spans DIV input clocks, marked by a start strobe and a mid-cycle strobe. A run/halt handshake lets the debug/test harness stop the processor cleanly on a processor-cycle boundary.

---
 rtl/clock_phase_sequencer_if.sv | 24 ++
 rtl/clock_phase_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/clock_phase_sequencer_if.sv
// Run/halt handshake and strobe bundle for clock_phase_sequencer.
// master drives run_req/halt_req; slave (the sequencer) drives the rest.
interface clock_phase_sequencer_if;
  logic        run_req;
  logic        halt_req;
  logic        proc_reset;
  logic        cyc_start;
  logic        mid_strobe;
  logic [7:0]  phase;
  logic        halted;
  logic [31:0] cycle_count;

  modport master (
    output run_req, halt_req,
    input  proc_reset, cyc_start, mid_strobe,
    input  phase, halted, cycle_count
  );

  modport slave (
    input  run_req, halt_req,
    output proc_reset, cyc_start, mid_strobe,
    output phase, halted, cycle_count
  );
endinterface

// File: rtl/clock_phase_sequencer.sv
// Phase sequencer: DIV-clock processor cycles as enables, stretched reset,
// run/halt on cycle boundaries. Ports: clock, reset (async low), bus.slave.
// Optional macro SEQ_CYCLE_COUNT_EN builds the 32-bit cycle_count register.
module clock_phase_sequencer #(
  parameter int DIV      = 4,
  parameter int RST_HOLD = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  clock_phase_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(DIV - 1);
  localparam logic [7:0] LP_MID  = 8'(DIV / 2);
  localparam logic [7:0] LP_HLD  = 8'(RST_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_phase;
  logic [7:0] r_hold_cnt;
  logic       r_proc_reset;
  logic       r_cyc_start;
  logic       r_mid_strobe;
  logic       r_halted;

  state_t     w_state_nxt;
  logic [7:0] w_phase_nxt;
  logic [7:0] w_hold_nxt;
  logic [7:0] w_phase_inc;
  logic       w_last;
  logic       w_active_nxt;

  assign w_last      = (r_phase == LP_LAST);
  assign w_phase_inc = w_last ? 8'd0 : r_phase + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == LP_HLD) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = 8'd0;
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      S_RUN: begin
        w_phase_nxt = w_phase_inc;
        // a halt on the last phase needs no drain
        if (bus.halt_req)
          w_state_nxt = w_last ? S_HALTED : S_DRAIN;
      end
      S_DRAIN: begin
        w_phase_nxt = w_phase_inc;
        if (w_last)
          w_state_nxt = S_HALTED;
      end
      S_HALTED: begin
        w_phase_nxt = 8'd0;
        if (bus.run_req && !bus.halt_req)
          w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_phase_nxt = 8'd0;
      end
    endcase
  end

  assign w_active_nxt = (w_state_nxt == S_RUN) ||
                        (w_state_nxt == S_DRAIN);

  // strobes are registered from next-state so they line up with phase
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_HOLD;
      r_phase      <= 8'd0;
      r_hold_cnt   <= 8'd0;
      r_proc_reset <= 1'b1;
      r_cyc_start  <= 1'b0;
      r_mid_strobe <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_proc_reset <= (w_state_nxt == S_HOLD);
      r_cyc_start  <= w_active_nxt && (w_phase_nxt == 8'd0);
      r_mid_strobe <= w_active_nxt && (w_phase_nxt == LP_MID);
      r_halted     <= (w_state_nxt == S_HALTED);
    end
  end

  assign bus.proc_reset = r_proc_reset;
  assign bus.cyc_start  = r_cyc_start;
  assign bus.mid_strobe = r_mid_strobe;
  assign bus.phase      = r_phase;
  assign bus.halted     = r_halted;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_cycle_count <= 32'd0;
    else
      r_cycle_count <= r_cycle_count + {31'd0, r_cyc_start};
  end

  assign bus.cycle_count = r_cycle_count;
`else
  assign bus.cycle_count = 32'd0;
`endif

endmodule
